// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the parameterised main-memory model.
// Holds the controller state encoding, the default geometry/latency of the
// memory, and the width of the latency counter (enough for LATENCY 1..255).
package mem_pkg;

    localparam int DEF_BLOCK_W = 128;
    localparam int DEF_DEPTH   = 8192;
    localparam int DEF_LATENCY = 20;

    // Latency counter width: LATENCY is at most 255.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_latency_counter.sv
// mem_latency_counter: up-counter timing the WAIT phase of a memory request.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high; clears the count to 0
//   load   - load the count with 1 (request accepted)
//   enable - increment the count by one
//   done   - high while the count equals LATENCY
module mem_latency_counter
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(LATENCY));

endmodule

// File: rtl/param_main_memory.sv
// param_main_memory: block-wide main memory with a fixed access latency.
// A request (optional block write plus optional block read) is captured on
// accept, waits LATENCY cycles, is performed in a single ACCESS cycle and
// completes with a one-cycle resp_valid pulse (LATENCY+2 cycles after accept).
// Ports:
//   clk, reset             - clock; synchronous active-high reset
//   req_valid / req_ready  - request handshake (ready only when idle)
//   req_read / req_write   - request includes a block read / block write
//   req_rd_addr/req_wr_addr- byte addresses of the read / write blocks
//   req_wr_data            - block to write
//   resp_valid             - one-cycle completion pulse
//   resp_data              - last read block, held between read completions
//   busy                   - request in flight
//   err                    - out-of-range access, valid with resp_valid
// Build option: define PARAM_MAIN_MEMORY_RANGE_CHECK_EN to suppress accesses
// whose address has bits set above the indexed range and flag them on err.
// Without it, upper address bits are ignored and err is tied low.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | latency counter running (counts 1..LATENCY)
// ACCESS | captured write/read performed this cycle
// DONE   | resp_valid (and err) presented for one cycle
module param_main_memory
    import mem_pkg::*;
#(
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_read,
    input  logic               req_write,
    input  logic [31:0]        req_rd_addr,
    input  logic [31:0]        req_wr_addr,
    input  logic [BLOCK_W-1:0] req_wr_data,
    output logic               resp_valid,
    output logic [BLOCK_W-1:0] resp_data,
    output logic               busy,
    output logic               err
);

    localparam int ADDR_LSB = $clog2(BLOCK_W / 8);
    localparam int IDX_W    = $clog2(DEPTH);

    mem_state_e state;

    logic               cap_read;
    logic               cap_write;
    logic [31:0]        cap_rd_addr;
    logic [31:0]        cap_wr_addr;
    logic [BLOCK_W-1:0] cap_wr_data;

    logic [BLOCK_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_blocked;
    logic             wr_blocked;
    logic             accept;
    logic             cnt_done;
    logic             unused_addr_bits;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    assign rd_idx = cap_rd_addr[ADDR_LSB +: IDX_W];
    assign wr_idx = cap_wr_addr[ADDR_LSB +: IDX_W];

    // Byte-offset bits (and upper bits in the wrapping build) are not used.
    assign unused_addr_bits = ^{cap_rd_addr, cap_wr_addr};

`ifdef PARAM_MAIN_MEMORY_RANGE_CHECK_EN
    assign rd_blocked = cap_read  && ((cap_rd_addr >> (ADDR_LSB + IDX_W)) != 32'd0);
    assign wr_blocked = cap_write && ((cap_wr_addr >> (ADDR_LSB + IDX_W)) != 32'd0);

    // Registered in ACCESS so it lines up with the resp_valid pulse in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == ACCESS) begin
            err <= rd_blocked || wr_blocked;
        end else begin
            err <= 1'b0;
        end
    end
`else
    assign rd_blocked = 1'b0;
    assign wr_blocked = 1'b0;
    assign err        = 1'b0;
`endif

    mem_latency_counter #(
        .LATENCY (LATENCY)
    ) u_latency_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .enable ((state == WAIT) && !cnt_done),
        .done   (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_read    <= req_read;
            cap_write   <= req_write;
            cap_rd_addr <= req_rd_addr;
            cap_wr_addr <= req_wr_addr;
            cap_wr_data <= req_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_done) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Reads the array before this edge's write lands, so a
                    // same-index read returns the pre-write block.
                    if (cap_read && !rd_blocked) begin
                        resp_data <= mem[rd_idx];
                    end
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // No reset on the array; a reset in ACCESS must still block the write.
    always_ff @(posedge clk) begin
        if (!reset && (state == ACCESS) && cap_write && !wr_blocked) begin
            mem[wr_idx] <= cap_wr_data;
        end
    end

endmodule

// File: tb/tb_param_main_memory.sv
module tb_param_main_memory;

    localparam int L0 = 20;
    localparam int L1 = 1;

    localparam logic [127:0] D_A = {16{8'hAA}};
    localparam logic [127:0] D_5 = {16{8'h55}};
    localparam logic [127:0] D_1 = {16{8'h11}};
    localparam logic [127:0] D_7 = {16{8'h77}};
    localparam logic [127:0] D_9 = {16{8'h99}};
    localparam logic [127:0] D_B = {4{32'hDEADBEEF}};
    localparam logic [127:0] D_X = {4{32'h0123ABCD}};
    localparam logic [127:0] D_Y = {4{32'hCAFEF00D}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         req_valid0, req_valid1, req_read, req_write;
    logic [31:0]  req_rd_addr, req_wr_addr;
    logic [127:0] req_wr_data;
    logic         req_ready0, resp_valid0, busy0, err0;
    logic         req_ready1, resp_valid1, busy1, err1;
    logic [127:0] resp_data0, resp_data1;

    param_main_memory #(.BLOCK_W(128), .DEPTH(8192), .LATENCY(L0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_read(req_read), .req_write(req_write), .req_rd_addr(req_rd_addr),
        .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .resp_valid(resp_valid0),
        .resp_data(resp_data0), .busy(busy0), .err(err0)
    );

    param_main_memory #(.BLOCK_W(128), .DEPTH(16), .LATENCY(L1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_read(req_read), .req_write(req_write), .req_rd_addr(req_rd_addr),
        .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .resp_valid(resp_valid1),
        .resp_data(resp_data1), .busy(busy1), .err(err1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        if (resp_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_resp0: resp_valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e0 = q0.pop_front();
                check("resp_data0", resp_data0, e0.data);
                check("err0", 128'(err0), 128'(e0.err));
                check("latency0", 128'(cyc), 128'(e0.cyc));
            end
        end
        if (resp_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_resp1: resp_valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e1 = q1.pop_front();
                check("resp_data1", resp_data1, e1.data);
                check("err1", 128'(err1), 128'(e1.err));
                check("latency1", 128'(cyc), 128'(e1.cyc));
            end
        end
    end

    task automatic issue(input int d, input logic rd, input logic wr,
                         input logic [31:0] ra, input logic [31:0] wa,
                         input logic [127:0] wd, input logic [127:0] ed,
                         input logic ee, input bit push, input bit keep,
                         output int acc);
        int n;
        n = 0;
        req_read    = rd;
        req_write   = wr;
        req_rd_addr = ra;
        req_wr_addr = wa;
        req_wr_data = wd;
        if (d == 0) req_valid0 = 1'b1;
        else        req_valid1 = 1'b1;
        while ((((d == 0) ? req_ready0 : req_ready1) !== 1'b1) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            exp_t e;
            e.data = ed;
            e.err  = ee;
            e.cyc  = acc + ((d == 0) ? L0 : L1) + 1;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (!keep) begin
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
        end
        // Scramble inputs after accept; the captured request must not change.
        req_read    = ~rd;
        req_write   = ~wr;
        req_rd_addr = ~ra;
        req_wr_addr = ~wa;
        req_wr_data = ~wd;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 128'(q0.size() + q1.size()), 128'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int a, a1, a2, a3;
    logic [127:0] exp_h;
    logic         exp_h_err;

    initial begin
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        req_read = 1'b0;
        req_write = 1'b0;
        req_rd_addr = '0;
        req_wr_addr = '0;
        req_wr_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_ready0", 128'(req_ready0), 128'd1);
        check("rst_busy0", 128'(busy0), 128'd0);
        check("rst_resp_valid0", 128'(resp_valid0), 128'd0);
        check("rst_resp_data0", resp_data0, 128'd0);
        check("rst_err0", 128'(err0), 128'd0);
        check("rst_resp_data1", resp_data1, 128'd0);

        // Write-only: resp_data stays at its reset value.
        issue(0, 1'b0, 1'b1, 32'h0, 32'h100, D_A, 128'd0, 1'b0, 1, 0, a);
        check("busy_after_accept", 128'(busy0), 128'd1);
        check("ready_after_accept", 128'(req_ready0), 128'd0);
        issue(0, 1'b1, 1'b0, 32'h100, 32'h0, '0, D_A, 1'b0, 1, 0, a);
        issue(0, 1'b0, 1'b1, 32'h0, 32'h200, D_1, D_A, 1'b0, 1, 0, a);
        // Same-index read+write returns pre-write contents.
        issue(0, 1'b1, 1'b1, 32'h200, 32'h200, D_5, D_1, 1'b0, 1, 0, a);
        issue(0, 1'b1, 1'b0, 32'h200, 32'h0, '0, D_5, 1'b0, 1, 0, a);
        // Neither read nor write.
        issue(0, 1'b0, 1'b0, 32'h100, 32'h100, D_7, D_5, 1'b0, 1, 0, a);
        issue(0, 1'b0, 1'b1, 32'h0, 32'h0, D_B, D_5, 1'b0, 1, 0, a);
`ifdef PARAM_MAIN_MEMORY_RANGE_CHECK_EN
        exp_h = D_5;
        exp_h_err = 1'b1;
`else
        exp_h = D_B;
        exp_h_err = 1'b0;
`endif
        issue(0, 1'b1, 1'b0, 32'h0002_0000, 32'h0, '0, exp_h, exp_h_err, 1, 0, a);

        // Back-to-back with req_valid held high.
        issue(0, 1'b1, 1'b0, 32'h000, 32'h0, '0, D_B, 1'b0, 1, 1, a1);
        issue(0, 1'b1, 1'b0, 32'h100, 32'h0, '0, D_A, 1'b0, 1, 1, a2);
        issue(0, 1'b1, 1'b0, 32'h200, 32'h0, '0, D_5, 1'b0, 1, 0, a3);
        check("b2b_spacing_1", 128'(a2 - a1), 128'(L0 + 3));
        check("b2b_spacing_2", 128'(a3 - a2), 128'(L0 + 3));
        drain();

        // Reset during WAIT aborts the write.
        issue(0, 1'b0, 1'b1, 32'h0, 32'h100, D_7, '0, 1'b0, 0, 0, a);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("ready_after_reset", 128'(req_ready0), 128'd1);
        check("resp_data_after_reset", resp_data0, 128'd0);
        repeat (30) @(posedge clk);
        #1;
        issue(0, 1'b1, 1'b0, 32'h100, 32'h0, '0, D_A, 1'b0, 1, 0, a);

        // Reset in the ACCESS cycle aborts the write.
        issue(0, 1'b0, 1'b1, 32'h0, 32'h200, D_9, '0, 1'b0, 0, 0, a);
        repeat (L0) @(posedge clk);
        #1;
        check("busy_in_access", 128'(busy0), 128'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        issue(0, 1'b1, 1'b0, 32'h200, 32'h0, '0, D_5, 1'b0, 1, 0, a);
        drain();

        // LATENCY=1 instance: 3-cycle response latency.
        issue(1, 1'b0, 1'b1, 32'h0, 32'h10, D_X, 128'd0, 1'b0, 1, 0, a);
        issue(1, 1'b1, 1'b0, 32'h10, 32'h0, '0, D_X, 1'b0, 1, 0, a);
        issue(1, 1'b1, 1'b1, 32'h10, 32'h10, D_Y, D_X, 1'b0, 1, 0, a);
        issue(1, 1'b1, 1'b0, 32'h10, 32'h0, '0, D_Y, 1'b0, 1, 0, a);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/param_main_memory.md
PARAM_MAIN_MEMORY -- requirements
Module: param_main_memory

Interface
REQ-001 Parameters SHALL be: BLOCK_W, default 128, data block width in bits; DEPTH, default 8192, number of blocks; LATENCY, default 20, cycles from accept to access, legal range 1..255.
REQ-002 Derived constants SHALL be: ADDR_LSB = log2(BLOCK_W/8); IDX_W = log2(DEPTH); DEPTH a power of two.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_read  input  1  request includes a block read.
REQ-008 req_write  input  1  request includes a block write.
REQ-009 req_rd_addr  input  32  byte address of the read block.
REQ-010 req_wr_addr  input  32  byte address of the write block.
REQ-011 req_wr_data  input  BLOCK_W  block to write.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_data  output  BLOCK_W  read block; held until the next read completion.
REQ-014 busy  output  1  high while a request is in flight.
REQ-015 err  output  1  out-of-range address flag, valid with resp_valid.

Function
REQ-016 States SHALL be IDLE, WAIT, ACCESS, DONE.
REQ-017 req_ready SHALL equal (state==IDLE); a request is accepted on a cycle with req_valid && req_ready.
REQ-018 On accept, addresses, write data, req_read and req_write SHALL be captured; later input changes have no effect.
REQ-019 IDLE->WAIT on accept, with counter loaded to 1.
REQ-020 WAIT SHALL increment the counter each cycle and go to ACCESS on the cycle counter==LATENCY.
REQ-021 ACCESS SHALL last one cycle, performing the captured write at index wr_addr[ADDR_LSB +: IDX_W] and the captured read at rd_addr[ADDR_LSB +: IDX_W].
REQ-022 A read to the same index as a write in the same request SHALL return the pre-write contents.
REQ-023 DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-024 Accept-to-resp_valid latency SHALL be LATENCY+2 cycles; back-to-back accepts SHALL be LATENCY+3 cycles apart.
REQ-025 A request with neither read nor write SHALL still complete with resp_valid, with no memory change and resp_data unchanged.
REQ-026 resp_data SHALL update only on reads; a write-only request SHALL leave it unchanged.
REQ-027 busy SHALL equal (state!=IDLE).
REQ-028 Address bits above ADDR_LSB+IDX_W-1 SHALL be ignored (modulo DEPTH) unless REQ-033 applies.

Reset
REQ-029 reset SHALL force state IDLE, counter 0, resp_valid 0, err 0, and resp_data to all zeros.
REQ-030 reset during WAIT or ACCESS SHALL abort the request: no write is committed and no resp_valid is produced.
REQ-031 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro PARAM_MAIN_MEMORY_RANGE_CHECK_EN SHALL control range checking.
REQ-033 With the macro defined, a captured enabled address with nonzero bits above ADDR_LSB+IDX_W-1 SHALL suppress that access, assert err with resp_valid, and leave resp_data unchanged for a suppressed read.
REQ-034 Without the macro, err SHALL be tied 0 and addresses wrap per REQ-028.

Structure
REQ-035 A shared package mem_pkg SHALL hold the state enum and the default BLOCK_W, DEPTH and LATENCY constants.
REQ-036 The latency counter SHALL be a sub-module mem_latency_counter with load, enable, LATENCY parameter and a done output.

Verification
REQ-037 Write 0xAAAA..AA to 0x100 -> resp_valid at accept+22 with LATENCY=20; a later read of 0x100 returns 0xAAAA..AA.
REQ-038 Combined request writing 0x5555..55 to 0x200 and reading 0x200, which holds 0x1111..11 -> resp_data=0x1111..11; a next read returns 0x5555..55.
REQ-039 req_valid held high for 3 requests -> req_ready low while busy; accepts 23 cycles apart; exactly 3 resp_valid pulses.
REQ-040 reset asserted 5 cycles after a write accept -> no resp_valid; a later read of the target returns the old contents; req_ready is high the cycle after reset.
REQ-041 Macro defined, read of 0x0002_0000 with DEPTH=8192 and BLOCK_W=128 -> err=1 with resp_valid and resp_data unchanged; without the macro, the same read returns the block at index 0.
REQ-042 LATENCY=1 build -> write-then-read completes with 3-cycle response latency.
